// File: rtl/alu_cr_writeback.sv
// Writeback stage behind the logical ALU: 2-entry result FIFO feeding the GPR write port,
// with record-form condition fields merged into the architectural CR on pop.
module alu_cr_writeback #(
  parameter int unsigned DWIDTH = 32,
  parameter int unsigned DEPTH  = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [DWIDTH-1:0] i_in_res,
  input  logic [3:0]        i_in_cr,
  input  logic              i_in_rc,
  input  logic [2:0]        i_in_crf,
  input  logic              i_in_gpr_we,
  input  logic [4:0]        i_in_gpr_dest,
  input  logic              i_xer_so,
  output logic              o_wb_valid,
  input  logic              i_wb_ready,
  output logic              o_wb_we,
  output logic [4:0]        o_wb_dest,
  output logic [DWIDTH-1:0] o_wb_data,
  input  logic              i_mtcrf_valid,
  input  logic [7:0]        i_mtcrf_mask,
  input  logic [31:0]       i_mtcrf_data,
  output logic [31:0]       o_cr
);

  if (DEPTH != 2) begin : g_depth_check
    $error("alu_cr_writeback supports DEPTH == 2 only");
  end

  logic [DWIDTH-1:0] r_res  [2];
  logic [2:0]        r_crv  [2];
  logic              r_so   [2];
  logic              r_rc   [2];
  logic [2:0]        r_crf  [2];
  logic              r_we   [2];
  logic [4:0]        r_dest [2];

  logic        r_wr_ptr;
  logic        r_rd_ptr;
  logic [1:0]  r_count;
  logic [31:0] r_cr;

  logic        w_push;
  logic        w_pop;
  logic [1:0]  w_count_d;
  logic [31:0] w_cr_d;
  logic [31:0] w_mtcrf_bits;

  assign o_in_ready = (r_count != 2'd2);
  assign o_wb_valid = (r_count != 2'd0);
  assign w_push     = i_in_valid && o_in_ready;
  assign w_pop      = o_wb_valid && i_wb_ready;

  assign o_wb_we   = o_wb_valid && r_we[r_rd_ptr];
  assign o_wb_dest = r_dest[r_rd_ptr];
  assign o_wb_data = r_res[r_rd_ptr];
  assign o_cr      = r_cr;

  always_comb begin
    w_count_d = r_count;
    unique case ({w_push, w_pop})
      2'b10:   w_count_d = r_count + 2'd1;
      2'b01:   w_count_d = r_count - 2'd1;
      default: w_count_d = r_count;
    endcase
  end

  // Mask bit 7 selects CR[31:28], so mask bit f maps straight onto nibble f.
  always_comb begin
    w_mtcrf_bits = '0;
    if (i_mtcrf_valid) begin
      for (int f = 0; f < 8; f++) begin
        w_mtcrf_bits[4*f +: 4] = {4{i_mtcrf_mask[f]}};
      end
    end
  end

  // Pop merge is applied last so it overrides mtcrf on the same field.
  always_comb begin
    w_cr_d = (r_cr & ~w_mtcrf_bits) | (i_mtcrf_data & w_mtcrf_bits);
    if (w_pop && r_rc[r_rd_ptr]) begin
      w_cr_d[{~r_crf[r_rd_ptr], 2'b00} +: 4] = {r_crv[r_rd_ptr], r_so[r_rd_ptr]};
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
      r_cr     <= 32'h0;
    end else begin
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
      r_count <= w_count_d;
      r_cr    <= w_cr_d;
    end
  end

  // Payload needs no reset: it is only observed while the entry is counted as valid.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_res[r_wr_ptr]  <= i_in_res;
      r_crv[r_wr_ptr]  <= i_in_cr[3:1];
      r_so[r_wr_ptr]   <= i_xer_so;
      r_rc[r_wr_ptr]   <= i_in_rc;
      r_crf[r_wr_ptr]  <= i_in_crf;
      r_we[r_wr_ptr]   <= i_in_gpr_we;
      r_dest[r_wr_ptr] <= i_in_gpr_dest;
    end
  end

endmodule

// File: tb/tb_alu_cr_writeback.sv
// Directed bench for alu_cr_writeback: hand-computed expectations checked with immediate asserts.
module tb_alu_cr_writeback;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_res;
  logic [3:0]  in_cr;
  logic        in_rc;
  logic [2:0]  in_crf;
  logic        in_gpr_we;
  logic [4:0]  in_gpr_dest;
  logic        xer_so;
  logic        wb_valid;
  logic        wb_ready;
  logic        wb_we;
  logic [4:0]  wb_dest;
  logic [31:0] wb_data;
  logic        mtcrf_valid;
  logic [7:0]  mtcrf_mask;
  logic [31:0] mtcrf_data;
  logic [31:0] cr;

  int errors = 0;
  int checks = 0;

  alu_cr_writeback #(.DWIDTH(32), .DEPTH(2)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_in_valid   (in_valid),
    .o_in_ready   (in_ready),
    .i_in_res     (in_res),
    .i_in_cr      (in_cr),
    .i_in_rc      (in_rc),
    .i_in_crf     (in_crf),
    .i_in_gpr_we  (in_gpr_we),
    .i_in_gpr_dest(in_gpr_dest),
    .i_xer_so     (xer_so),
    .o_wb_valid   (wb_valid),
    .i_wb_ready   (wb_ready),
    .o_wb_we      (wb_we),
    .o_wb_dest    (wb_dest),
    .o_wb_data    (wb_data),
    .i_mtcrf_valid(mtcrf_valid),
    .i_mtcrf_mask (mtcrf_mask),
    .i_mtcrf_data (mtcrf_data),
    .o_cr         (cr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] res, input logic [3:0] c,
                       input logic rc, input logic [2:0] crf, input logic so,
                       input logic we, input logic [4:0] dest);
    in_valid    = v;
    in_res      = res;
    in_cr       = c;
    in_rc       = rc;
    in_crf      = crf;
    xer_so      = so;
    in_gpr_we   = we;
    in_gpr_dest = dest;
  endtask

  initial begin
    rst_n       = 1'b0;
    wb_ready    = 1'b0;
    mtcrf_valid = 1'b0;
    mtcrf_mask  = 8'h00;
    mtcrf_data  = 32'h0;
    drive(1'b0, 32'h0, 4'h0, 1'b0, 3'd0, 1'b0, 1'b0, 5'd0);
    #12;
    chk("rst_wb_valid", {31'b0, wb_valid}, 32'd0);
    chk("rst_wb_we",    {31'b0, wb_we},    32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_cr",       cr,                32'h0);
    step();
    rst_n = 1'b1;
    step();

    // Single record-form result: SO comes from XER.
    wb_ready = 1'b1;
    drive(1'b1, 32'hFFFF_0000, 4'b1000, 1'b1, 3'd0, 1'b1, 1'b1, 5'd3);
    step();
    drive(1'b0, 32'h0, 4'h0, 1'b0, 3'd0, 1'b0, 1'b0, 5'd0);
    chk("t1_wb_valid", {31'b0, wb_valid}, 32'd1);
    chk("t1_wb_we",    {31'b0, wb_we},    32'd1);
    chk("t1_wb_dest",  {27'b0, wb_dest},  32'd3);
    chk("t1_wb_data",  wb_data,           32'hFFFF_0000);
    chk("t1_cr_before_pop", cr,           32'h0);
    step();
    chk("t1_cr_after_pop", cr,            32'h9000_0000);
    chk("t1_empty",    {31'b0, wb_valid}, 32'd0);

    // Back-pressure: fill, hold a third, then drain in order.
    wb_ready = 1'b0;
    drive(1'b1, 32'h1, 4'h0, 1'b0, 3'd0, 1'b0, 1'b1, 5'd1);
    step();
    chk("t2_ready_one", {31'b0, in_ready}, 32'd1);
    drive(1'b1, 32'h2, 4'h0, 1'b0, 3'd0, 1'b0, 1'b1, 5'd2);
    step();
    chk("t2_ready_full", {31'b0, in_ready}, 32'd0);
    drive(1'b1, 32'h3, 4'h0, 1'b0, 3'd0, 1'b0, 1'b1, 5'd4);
    step();
    chk("t2_held_ready", {31'b0, in_ready}, 32'd0);
    chk("t2_stable_data", wb_data,          32'h1);
    chk("t2_stable_dest", {27'b0, wb_dest}, 32'd1);
    wb_ready = 1'b1;
    step();
    chk("t2_second", wb_data,              32'h2);
    chk("t2_ready_after_pop", {31'b0, in_ready}, 32'd1);
    step();
    drive(1'b0, 32'h0, 4'h0, 1'b0, 3'd0, 1'b0, 1'b0, 5'd0);
    chk("t2_third", wb_data,               32'h3);
    chk("t2_third_dest", {27'b0, wb_dest}, 32'd4);
    step();
    chk("t2_drained", {31'b0, wb_valid},   32'd0);
    chk("t2_cr_unchanged", cr,             32'h9000_0000);

    // Count=1 with simultaneous push and pop; pointers wrap repeatedly.
    drive(1'b1, 32'd100, 4'h0, 1'b0, 3'd0, 1'b0, 1'b1, 5'd7);
    step();
    for (int i = 1; i <= 6; i++) begin
      drive(1'b1, 32'd100 + 32'(i), 4'h0, 1'b0, 3'd0, 1'b0, 1'b1, 5'd7);
      step();
      chk("t3_stream_data",  wb_data,            32'd100 + 32'(i));
      chk("t3_stream_ready", {31'b0, in_ready},  32'd1);
    end
    drive(1'b0, 32'h0, 4'h0, 1'b0, 3'd0, 1'b0, 1'b0, 5'd0);
    step();
    chk("t3_empty", {31'b0, wb_valid}, 32'd0);

    // mtcrf and rc-pop in the same cycle; pop wins field 1.
    wb_ready = 1'b0;
    drive(1'b1, 32'h5, 4'b0010, 1'b1, 3'd1, 1'b0, 1'b0, 5'd0);
    step();
    drive(1'b0, 32'h0, 4'h0, 1'b0, 3'd0, 1'b0, 1'b0, 5'd0);
    chk("t4_we_gated", {31'b0, wb_we},     32'd0);
    chk("t4_valid",    {31'b0, wb_valid},  32'd1);
    mtcrf_valid = 1'b1;
    mtcrf_mask  = 8'hC0;
    mtcrf_data  = 32'hA500_0000;
    wb_ready    = 1'b1;
    step();
    mtcrf_valid = 1'b0;
    chk("t4_cr_merge", cr, 32'hA200_0000);

    // XER SO overrides the ALU SO bit.
    drive(1'b1, 32'h6, 4'b1001, 1'b1, 3'd7, 1'b0, 1'b1, 5'd9);
    step();
    drive(1'b0, 32'h0, 4'h0, 1'b0, 3'd0, 1'b0, 1'b0, 5'd0);
    chk("t5_dest", {27'b0, wb_dest}, 32'd9);
    step();
    chk("t5_cr_so", cr, 32'hA200_0008);

    // mtcrf alone on field 7.
    mtcrf_valid = 1'b1;
    mtcrf_mask  = 8'h01;
    mtcrf_data  = 32'hFFFF_FFF5;
    step();
    mtcrf_valid = 1'b0;
    chk("t5_mtcrf_only", cr, 32'hA200_0005);

    // Asynchronous reset with two entries pending.
    wb_ready = 1'b0;
    drive(1'b1, 32'h7, 4'b1110, 1'b1, 3'd2, 1'b1, 1'b1, 5'd5);
    step();
    step();
    drive(1'b0, 32'h0, 4'h0, 1'b0, 3'd0, 1'b0, 1'b0, 5'd0);
    chk("t6_full", {31'b0, in_ready}, 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_valid", {31'b0, wb_valid}, 32'd0);
    chk("t6_async_cr",    cr,                32'h0);
    chk("t6_async_ready", {31'b0, in_ready}, 32'd1);
    step();
    rst_n    = 1'b1;
    wb_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t6_no_we",  {31'b0, wb_we}, 32'd0);
      chk("t6_cr_zero", cr,            32'h0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_cr_writeback.md
# alu_cr_writeback

Writeback stage directly downstream of the logical ALU. It accepts each ALU result with its four-bit condition field, buffers up to two results in a FIFO, and presents them in order to the GPR write port. For record-form instructions it merges the condition field into the 32-bit condition register (CR). Before the merge, the SO bit is replaced by the XER summary-overflow value sampled when the result is accepted.

## Interface
Parameters:
- DWIDTH, 32, result width.
- DEPTH, 2, FIFO entries. Only 2 is supported; any other value is a compile-time error.

Ports:
- clk  in  1  single clock; all state changes on rising edge
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  ALU result valid
- in_ready  out  1  stage can accept (registered-state only, no combinational path from wb_ready)
- in_res  in  DWIDTH  ALU result word
- in_cr  in  4  condition field {lt,gt,eq,so}
- in_rc  in  1  record form: update CR field in_crf
- in_crf  in  3  target CR field index (0 = CR[31:28], 7 = CR[3:0])
- in_gpr_we  in  1  result writes a GPR
- in_gpr_dest  in  5  destination GPR
- xer_so  in  1  current XER[SO], sampled on acceptance
- wb_valid  out  1  head entry present
- wb_ready  in  1  register file accepts head
- wb_we  out  1  head gpr_we, gated by wb_valid
- wb_dest  out  5  head destination
- wb_data  out  DWIDTH  head result
- mtcrf_valid  in  1  direct CR write strobe
- mtcrf_mask  in  8  field mask; bit 7 selects field 0
- mtcrf_data  in  32  CR write data
- cr  out  32  architectural CR register

## Operation
- Storage is a 2-entry circular FIFO. Each entry holds res, cr[3:1], the sampled so, rc, crf, gpr_we and dest.
- Pointers wr_ptr/rd_ptr are 1 bit each, and count is 2 bits (0..2).
- Push: in_valid && in_ready.
  - Write the entry at wr_ptr.
  - Stored so = xer_so; the in_cr[0] value is discarded.
  - wr_ptr toggles.
- Pop: wb_valid && wb_ready. rd_ptr toggles.
  - If the popped entry has rc=1, CR field crf becomes {lt,gt,eq,so_sampled}.
  - If rc=0, CR is unchanged.
- wb_valid = (count != 0). wb_we/wb_dest/wb_data are driven from the head entry. wb_we = wb_valid && head.gpr_we.
- An entry with gpr_we=0 and rc=0 still occupies a slot and is popped normally.
- in_ready = (count != DEPTH). When full, no push occurs even if a pop happens in the same cycle.
- Count update on simultaneous push+pop (count 1): count stays 1, both pointers advance.
- mtcrf: for each mask bit set, the corresponding CR field is loaded from the same bits of mtcrf_data.
- Same-cycle mtcrf and rc-pop:
  - If both target the same field, the pop wins.
  - All other masked fields take mtcrf_data.
- Pointer wrap: 1-bit pointers wrap naturally from 1 to 0.
- No state machine beyond the FIFO occupancy (EMPTY=0, ONE=1, FULL=2):
  - EMPTY → ONE on push
  - ONE → FULL on push without pop
  - ONE → EMPTY on pop without push
  - FULL → ONE on pop

## Timing
- Reset (asynchronous assert, synchronous deassert by system):
  - count=0, pointers=0, cr=32'h0
  - wb_valid=0, wb_we=0, in_ready=1
  - wb_dest and wb_data read the (don't-care) head entry.
- Reset mid-operation: all buffered entries are discarded and cr clears. No GPR write is issued for discarded entries.
- Latency: an entry pushed at edge N has wb_valid=1 in cycle N+1. No fall-through in the same cycle.
- CR update from a pop at edge M is visible on cr from cycle M+1.
- Throughput: one result per cycle sustained while wb_ready=1.
- wb_valid/data are stable while wb_ready=0 (no retraction, no data change).
- in_ready depends only on registered count, never on wb_ready or in_valid in the same cycle.

## Test plan
- Reset, then push {res=32'hFFFF_0000, cr=4'b1000, rc=1, crf=0, xer_so=1, we=1, dest=3} with wb_ready=1 → cycle+1 shows wb_we=1, dest=3, data=FFFF_0000; after the pop, cr=32'h9000_0000.
- Hold wb_ready=0 and push 3 back-to-back → first two are accepted, in_ready=0 from the cycle after the second. The third is held until a pop; after the pop, entries drain in order 1,2,3.
- Count=1 with simultaneous push and pop, repeated over 6 cycles → count stays 1, order is preserved, and pointers wrap without loss.
- Same cycle: mtcrf mask=8'hC0, data=32'hA500_0000, plus a pop with rc=1, crf=1, cr={0,0,1}, so=0 → cr[31:28]=4'hA, cr[27:24]=4'h2.
- Entry with rc=1, in_cr[0]=1, xer_so=0 → the stored field has so=0 (XER overrides ALU).
- Assert reset with 2 entries pending → wb_valid=0, cr=0 immediately (asynchronous), and no wb_we pulse after deassertion.
